q_arm_selector: RTL
===================

Q_ARM_SELECTOR -- requirements
Module: q_arm_selector

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: cycles allowed between the first and second Q capture of a round; 0 disables the timeout.
REQ-002 Parameter TIE_ARM, default 0: arm index reported when the two Q values compare equal.
REQ-003 clk  input  1  single clock; all logic is rising-edge.
REQ-004 s_aresetn  input  1  asynchronous, active-low reset.
REQ-005 Q1_t  input  32  IEEE-754 single-precision Q value of arm 1; sampled only when float_Q1_valid=1.
REQ-006 float_Q1_valid  input  1  one-cycle strobe qualifying Q1_t.
REQ-007 Q2_t  input  32  IEEE-754 single-precision Q value of arm 2; sampled only when float_Q2_valid=1.
REQ-008 float_Q2_valid  input  1  one-cycle strobe qualifying Q2_t.
REQ-009 inform  output  32  decision word returned to the arm machine.
REQ-010 inform_valid  output  1  inform is valid; held until accepted.
REQ-011 inform_ready  input  1  consumer accepts inform when inform_valid=1 and inform_ready=1 on the same edge.

Function
REQ-012 inform layout: [31]=arm (0=arm 1, 1=arm 2), [30]=timeout flag, [29:16]=14-bit round number, [15:0]=bits [31:16] of the winning Q.
REQ-013 Capture registers: a valid strobe loads its Q register and sets a "have" flag in every state; a repeat strobe for an already-held arm overwrites the value (latest wins).
REQ-014 Both strobes in the same cycle capture both values in that cycle.
REQ-015 FSM states: COLLECT, DECIDE, SEND.
REQ-016 COLLECT -> DECIDE: on the cycle after both have-flags are set.
REQ-017 COLLECT -> DECIDE (timeout): when exactly one flag is set and TIMEOUT_CYCLES cycles have elapsed since that flag was set; only the held arm is eligible.
REQ-018 The timeout counter clears when the round's first flag is set.
REQ-019 DECIDE is one cycle:
  - snapshot the held Q values;
  - clear both have-flags;
  - register inform;
  - assert inform_valid on the next cycle in state SEND.
REQ-020 A strobe arriving during DECIDE or SEND counts toward the next round: its flag is set after the clear.
REQ-021 SEND: inform and inform_valid remain stable until handshake; on handshake go to COLLECT, deassert inform_valid, and increment the round counter.
REQ-022 Round counter: 14 bits, wraps 16383 -> 0.
REQ-023 Decision latency: inform_valid rises 2 cycles after the edge that captures the second Q.
REQ-024 Compare rule: full IEEE-754 ordering on sign/exponent/mantissa:
  - +0 equals -0;
  - NaN is less than any non-NaN;
  - two NaNs are equal;
  - greater value wins;
  - equality gives TIE_ARM.
REQ-025 Timeout decision: arm = held arm, flag [30]=1, [15:0] taken from the held arm's Q.

Reset
REQ-026 While s_aresetn=0, outputs are asynchronously forced: inform=0, inform_valid=0.
REQ-027 While s_aresetn=0, internal state is asynchronously forced:
  - state=COLLECT;
  - have-flags=0;
  - Q registers=0;
  - round counter=0;
  - timeout counter=0.
REQ-028 Reset asserted mid-SEND drops inform_valid immediately; the pending decision is lost and no handshake is recorded.
REQ-029 After deassertion, strobes are honoured from the first rising edge.

Verification
REQ-030 Q1=0x40400000 (3.0) at cycle 0, Q2=0x40000000 (2.0) at cycle 3, ready=1 -> inform_valid at cycle 5, inform=0x00004040, then round=1.
REQ-031 Both strobes same cycle, Q1=0xC0000000 (-2.0), Q2=0x3F800000 (1.0) -> inform=0x80003F80; Q1=0x80000000 (-0), Q2=0x00000000 (+0), TIE_ARM=0 -> arm bit 0.
REQ-032 Q1=0x7FC00000 (NaN), Q2=0xFF800000 (-inf) -> arm 2, [15:0]=0xFF80.
REQ-033 TIMEOUT_CYCLES=4, only Q2=0x41200000 strobed -> decision after 4 cycles, inform=0xC0004120; a later Q1 strobe counts toward round 1.
REQ-034 inform_ready=0 for 10 cycles with a new Q1/Q2 pair strobed during SEND -> inform stable throughout; after handshake the next round decides immediately with round=1.
REQ-035 Round counter preloaded via 16384 handshakes -> field wraps to 0.
REQ-036 s_aresetn pulsed low during SEND -> inform_valid=0 the same cycle and all fields zero.

Source files
------------

// File: rtl/q_arm_selector.sv
`default_nettype none
// +------------------------------------------------------------------+
// | q_arm_selector: picks the larger of two float32 Q values per round |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module q_arm_selector #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIE_ARM        = 0
) (
  input  logic        clk,
  input  logic        s_aresetn,
  input  logic [31:0] Q1_t,
  input  logic        float_Q1_valid,
  input  logic [31:0] Q2_t,
  input  logic        float_Q2_valid,
  output logic [31:0] inform,
  output logic        inform_valid,
  input  logic        inform_ready
);

  localparam logic [1:0] c_ST_COLLECT = 2'd0;
  localparam logic [1:0] c_ST_DECIDE  = 2'd1;
  localparam logic [1:0] c_ST_SEND    = 2'd2;

  localparam int c_TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_TMO_W-1:0] c_TMO_LAST =
    (TIMEOUT_CYCLES > 0) ? c_TMO_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic c_TMO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic c_TIE    = (TIE_ARM != 0);

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic               r_have1;
  logic               r_have2;
  logic [31:0]        r_q1;
  logic [31:0]        r_q2;
  logic [c_TMO_W-1:0] r_tmo;
  logic [13:0]        r_round;
  logic [31:0]        r_inform;
  logic               r_valid;

  logic        w_clr;
  logic        w_both;
  logic        w_one;
  logic        w_had_any;
  logic        w_tmo_hit;
  logic        w_nan1;
  logic        w_nan2;
  logic [31:0] w_key1;
  logic [31:0] w_key2;
  logic        w_arm;
  logic [31:0] w_win;
  logic [31:0] w_inform;

  function automatic logic is_nan(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
  endfunction

  // Monotonic unsigned key for non-NaN floats; both zeros share one key.
  function automatic logic [31:0] order_key(input logic [31:0] f);
    if (f[30:0] == 31'd0)
      return 32'h8000_0000;
    else if (f[31])
      return ~f;
    else
      return f | 32'h8000_0000;
  endfunction

  assign w_clr     = (r_state == c_ST_DECIDE);
  assign w_both    = r_have1 & r_have2;
  assign w_one     = r_have1 ^ r_have2;
  assign w_had_any = (r_have1 | r_have2) & ~w_clr;
  assign w_tmo_hit = c_TMO_EN & w_one & (r_tmo == c_TMO_LAST);

  assign w_nan1 = is_nan(r_q1);
  assign w_nan2 = is_nan(r_q2);
  assign w_key1 = order_key(r_q1);
  assign w_key2 = order_key(r_q2);

  always_comb begin
    w_arm = c_TIE;
    if (!w_both)
      w_arm = r_have2;
    else if (w_nan1 && w_nan2)
      w_arm = c_TIE;
    else if (w_nan1)
      w_arm = 1'b1;
    else if (w_nan2)
      w_arm = 1'b0;
    else if (w_key1 > w_key2)
      w_arm = 1'b0;
    else if (w_key2 > w_key1)
      w_arm = 1'b1;
  end

  assign w_win    = w_arm ? r_q2 : r_q1;
  assign w_inform = {w_arm, ~w_both, r_round, w_win[31:16]};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_COLLECT: if (w_both || w_tmo_hit) w_state_nxt = c_ST_DECIDE;
      c_ST_DECIDE:  w_state_nxt = c_ST_SEND;
      c_ST_SEND:    if (inform_ready) w_state_nxt = c_ST_COLLECT;
      default:      w_state_nxt = c_ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge s_aresetn) begin
    if (!s_aresetn)
      r_state <= c_ST_COLLECT;
    else
      r_state <= w_state_nxt;
  end

  // A strobe landing on the DECIDE edge survives the clear and opens the next round.
  always_ff @(posedge clk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      r_have1 <= 1'b0;
      r_have2 <= 1'b0;
      r_q1    <= '0;
      r_q2    <= '0;
    end else begin
      r_have1 <= float_Q1_valid | (r_have1 & ~w_clr);
      r_have2 <= float_Q2_valid | (r_have2 & ~w_clr);
      if (float_Q1_valid) r_q1 <= Q1_t;
      if (float_Q2_valid) r_q2 <= Q2_t;
    end
  end

  always_ff @(posedge clk or negedge s_aresetn) begin
    if (!s_aresetn)
      r_tmo <= '0;
    else if ((float_Q1_valid | float_Q2_valid) && !w_had_any)
      r_tmo <= '0;
    else if (w_one && !w_clr && (r_tmo != c_TMO_LAST))
      r_tmo <= r_tmo + 1'b1;
  end

  always_ff @(posedge clk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      r_inform <= '0;
      r_valid  <= 1'b0;
      r_round  <= '0;
    end else begin
      if (r_state == c_ST_DECIDE) begin
        r_inform <= w_inform;
        r_valid  <= 1'b1;
      end else if ((r_state == c_ST_SEND) && inform_ready) begin
        r_valid <= 1'b0;
        r_round <= r_round + 14'd1;
      end
    end
  end

  assign inform       = r_inform;
  assign inform_valid = r_valid;

endmodule
`default_nettype wire
